// File: rtl/vga_frame_reader.sv
// VGA raster timing plus frame-buffer scanout, gated per frame by frame_ready.
// Optional build macro TEST_PATTERN_EN adds a test_mode input selecting an x^y test pattern.
module vga_frame_reader #(
   parameter int unsigned H_DISPLAY = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_DISPLAY = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter int unsigned ADDR_W    = 19,
   parameter int unsigned PIX_W     = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_ready,
`ifdef TEST_PATTERN_EN
   input  logic              test_mode,
`endif
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [PIX_W-1:0]  rd_data,
   output logic              hsync,
   output logic              vsync,
   output logic              de,
   output logic [PIX_W-1:0]  pixel,
   output logic              frame_start
);

   localparam int unsigned H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned HW           = $clog2(H_TOTAL);
   localparam int unsigned VW           = $clog2(V_TOTAL);
   localparam int unsigned H_SYNC_START = H_DISPLAY + H_FRONT;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int unsigned V_SYNC_START = V_DISPLAY + V_FRONT;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

   localparam logic [HW-1:0]     H_LAST    = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0]     V_LAST    = VW'(V_TOTAL - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_DISPLAY * V_DISPLAY - 1);

   typedef enum logic [0:0] {StIdle, StScan} state_e;

   state_e            state_q, state_d;
   logic [HW-1:0]     h_cnt_q, h_cnt_d;
   logic [VW-1:0]     v_cnt_q, v_cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   logic line_end, frame_end, visible, scan_rd, pattern_sel;
   logic hsync0, vsync0, frame_start0;

   // stage-1 registers (memory data returns alongside these)
   logic hsync_q1, vsync_q1, de_q1, frame_start_q1, rd_valid_q1;
   logic [PIX_W-1:0] pixel_d;

`ifdef TEST_PATTERN_EN
   logic [PIX_W-1:0] pattern0, pattern_q1;
   logic             pattern_sel_q1;

   assign pattern_sel = test_mode;
   assign pattern0    = PIX_W'(h_cnt_q) ^ PIX_W'(v_cnt_q);
`else
   assign pattern_sel = 1'b0;
`endif

   // Stage 0: raster counters and decode
   assign line_end  = (h_cnt_q == H_LAST);
   assign frame_end = line_end && (v_cnt_q == V_LAST);
   assign visible   = (h_cnt_q < HW'(H_DISPLAY)) && (v_cnt_q < VW'(V_DISPLAY));

   assign hsync0 = !((h_cnt_q >= HW'(H_SYNC_START)) && (h_cnt_q < HW'(H_SYNC_END)));
   assign vsync0 = !((v_cnt_q >= VW'(V_SYNC_START)) && (v_cnt_q < VW'(V_SYNC_END)));
   assign frame_start0 = (h_cnt_q == '0) && (v_cnt_q == '0);

   always_comb begin
      h_cnt_d = line_end ? '0 : h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (line_end) begin
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end
   end

   // Arm/disarm only at the frame boundary so a frame is always shown whole
   always_comb begin
      state_d = state_q;
      if (frame_end) begin
         unique case (state_q)
            StIdle:  if (frame_ready)  state_d = StScan;
            StScan:  if (!frame_ready) state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   // Address follows the raster even while the pattern suppresses reads,
   // so leaving test_mode mid-frame still reads the right pixel.
   assign scan_rd = (state_q == StScan) && visible;
   assign rd_en   = scan_rd && !pattern_sel;
   assign rd_addr = addr_q;

   always_comb begin
      addr_d = addr_q;
      if (frame_end) begin
         addr_d = '0;
      end else if (scan_rd && (addr_q != ADDR_LAST)) begin
         addr_d = addr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         addr_q  <= addr_d;
      end
   end

   // Stage 1: timing delayed one clk while the memory read completes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hsync_q1       <= 1'b1;
         vsync_q1       <= 1'b1;
         de_q1          <= 1'b0;
         frame_start_q1 <= 1'b0;
         rd_valid_q1    <= 1'b0;
      end else begin
         hsync_q1       <= hsync0;
         vsync_q1       <= vsync0;
         de_q1          <= visible;
         frame_start_q1 <= frame_start0;
         rd_valid_q1    <= rd_en;
      end
   end

`ifdef TEST_PATTERN_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pattern_q1     <= '0;
         pattern_sel_q1 <= 1'b0;
      end else begin
         pattern_q1     <= pattern0;
         pattern_sel_q1 <= pattern_sel;
      end
   end
`endif

   // rd_valid_q1 already implies de && SCAN for the returning word
   always_comb begin
      pixel_d = '0;
      if (rd_valid_q1) begin
         pixel_d = rd_data;
      end
`ifdef TEST_PATTERN_EN
      if (pattern_sel_q1 && de_q1) begin
         pixel_d = pattern_q1;
      end
`endif
   end

   // Stage 2: registered outputs, all aligned with pixel
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         de          <= 1'b0;
         frame_start <= 1'b0;
         pixel       <= '0;
      end else begin
         hsync       <= hsync_q1;
         vsync       <= vsync_q1;
         de          <= de_q1;
         frame_start <= frame_start_q1;
         pixel       <= pixel_d;
      end
   end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader on a shrunken raster; expected outputs come from
// raster position arithmetic over a cycle count since reset release.
module tb_vga_frame_reader;

   localparam int HD = 16, HF = 2, HS = 3, HB = 3;
   localparam int VD = 8, VF = 1, VS = 2, VB = 2;
   localparam int HT = HD + HF + HS + HB;
   localparam int VT = VD + VF + VS + VB;
   localparam int FR = HT * VT;
   localparam int NPIX = HD * VD;
   localparam int AW = 19, PW = 8;

   typedef struct packed {
      logic          hs;
      logic          vs;
      logic          de;
      logic          fs;
      logic [PW-1:0] pix;
   } out_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          frame_ready;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [PW-1:0] rd_data;
   logic          hsync, vsync, de, frame_start;
   logic [PW-1:0] pixel;
`ifdef TEST_PATTERN_EN
   logic          test_mode;
`endif

   always #5 clk = ~clk;

   vga_frame_reader #(
      .H_DISPLAY (HD), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
      .V_DISPLAY (VD), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
      .ADDR_W    (AW), .PIX_W   (PW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .frame_ready (frame_ready),
`ifdef TEST_PATTERN_EN
      .test_mode   (test_mode),
`endif
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .hsync       (hsync),
      .vsync       (vsync),
      .de          (de),
      .pixel       (pixel),
      .frame_start (frame_start)
   );

   // Synchronous-read memory; garbage on idle cycles exposes missing gating
   logic [PW-1:0] mem [NPIX];
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[int'(rd_addr) % NPIX];
      else       rd_data <= PW'($urandom);
   end

   int   tests = 0;
   int   fails = 0;
   int   k;
   int   reads, exp_reads;
   bit   scan_hist [64];
   out_t pipe [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, k);
      end
   endtask

   task automatic check_reset_values();
      check("rst_hsync", 32'(hsync), 32'd1);
      check("rst_vsync", 32'(vsync), 32'd1);
      check("rst_de", 32'(de), 32'd0);
      check("rst_pixel", 32'(pixel), 32'd0);
      check("rst_rd_en", 32'(rd_en), 32'd0);
      check("rst_rd_addr", 32'(rd_addr), 32'd0);
      check("rst_frame_start", 32'(frame_start), 32'd0);
   endtask

   // Assert reset asynchronously, check immediately, release after one edge
   task automatic do_reset();
      reset = 1'b1;
      #2;
      check_reset_values();
      @(posedge clk);
      #1;
      reset = 1'b0;
      k = 0;
      reads = 0;
      exp_reads = 0;
      pipe.delete();
      foreach (scan_hist[i]) scan_hist[i] = 1'b0;
   endtask

   // One pixel clock: check position k, then advance past the next edge
   task automatic cycle();
      int   pos, f, x, y;
      bit   scan, tm, vis, exp_rd;
      out_t e;
      @(negedge clk);
      pos  = k % FR;
      f    = k / FR;
      x    = pos % HT;
      y    = pos / HT;
      scan = scan_hist[f];
      tm   = 1'b0;
`ifdef TEST_PATTERN_EN
      tm   = test_mode;
`endif
      vis    = (x < HD) && (y < VD);
      exp_rd = scan && vis && !tm;

      check("rd_en", 32'(rd_en), 32'(exp_rd));
      if (exp_rd) check("rd_addr", 32'(rd_addr), 32'(y * HD + x));
      reads     += int'(rd_en);
      exp_reads += int'(exp_rd);

      e.hs  = !((x >= HD + HF) && (x < HD + HF + HS));
      e.vs  = !((y >= VD + VF) && (y < VD + VF + VS));
      e.de  = vis;
      e.fs  = (pos == 0);
      e.pix = '0;
      if (vis && tm)        e.pix = PW'(x ^ y);
      else if (vis && scan) e.pix = mem[y * HD + x];
      pipe.push_back(e);

      // Outputs lag the counters by two clocks
      if (pipe.size() > 2) e = pipe.pop_front();
      else                 e = '{hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0, pix: '0};
      check("hsync", 32'(hsync), 32'(e.hs));
      check("vsync", 32'(vsync), 32'(e.vs));
      check("de", 32'(de), 32'(e.de));
      check("frame_start", 32'(frame_start), 32'(e.fs));
      check("pixel", 32'(pixel), 32'(e.pix));

      if (pos == FR - 1) begin
         check("reads_per_frame", 32'(reads), 32'(exp_reads));
         reads = 0;
         exp_reads = 0;
         scan_hist[f + 1] = frame_ready;
      end
      @(posedge clk);
      #1;
      k++;
   endtask

   initial begin
      foreach (mem[i]) mem[i] = PW'($urandom);
      frame_ready = 1'b0;
`ifdef TEST_PATTERN_EN
      test_mode = 1'b0;
`endif
      do_reset();

      // Idle frames: timing only, no reads, black pixels
      repeat (2 * FR) cycle();

      // Arm mid-frame; takes effect at the next boundary, then several full frames
      repeat ($urandom_range(HT, FR - HT)) cycle();
      frame_ready = 1'b1;
      repeat (4 * FR) cycle();

      // Disarm mid-frame; current frame still completes
      repeat ($urandom_range(HT, FR - HT)) cycle();
      frame_ready = 1'b0;
      repeat (2 * FR) cycle();

      // Random arm/disarm activity
      repeat (3 * FR) begin
         if ($urandom_range(0, 99) < 2) frame_ready = ~frame_ready;
         cycle();
      end

      // Reset in the middle of a scanned frame, frame_ready held high
      frame_ready = 1'b1;
      repeat (FR + 1) cycle();
      repeat ($urandom_range(HT, FR - HT)) cycle();
      do_reset();
      repeat (3 * FR) cycle();

`ifdef TEST_PATTERN_EN
      test_mode = 1'b1;
      repeat (2 * FR) begin
         if ($urandom_range(0, 99) < 2) frame_ready = ~frame_ready;
         cycle();
      end
      test_mode = 1'b0;
      frame_ready = 1'b1;
      repeat (2 * FR) cycle();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
